// File: rtl/lfsr_random_generator_if.sv
// ============================================================================
// Module : lfsr_random_generator_if
// Brief  : Request/response bundle between a client and the LFSR generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lfsr_random_generator_if #(
  parameter int WIDTH = 26
) ();

  logic [WIDTH-1:0] initialFill;
  logic             loadSeed;
  logic             generateNumber;
  logic [WIDTH-1:0] randomNumber;
  logic             numberValid;
  logic             busy;
  logic             periodWrap;

  modport master (
    output initialFill, loadSeed, generateNumber,
    input  randomNumber, numberValid, busy, periodWrap
  );

  modport slave (
    input  initialFill, loadSeed, generateNumber,
    output randomNumber, numberValid, busy, periodWrap
  );

endinterface

`default_nettype wire

// File: rtl/lfsr_random_generator.sv
// ============================================================================
// Module : lfsr_random_generator
// Brief  : Galois LFSR producing one number per request after STEPS shifts.
//          Optional macro LFSR_LOCKUP_GUARD_EN replaces an all-zero seed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_random_generator #(
  parameter int               WIDTH        = 26,
  parameter logic [WIDTH-1:0] TAPS         = 26'h3880000,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
  input  wire                      clock,
  input  wire                      resetN,
  lfsr_random_generator_if.slave   bus
);

  localparam logic [0:0] c_stateIdle  = 1'b0;
  localparam logic [0:0] c_stateShift = 1'b1;
  localparam logic [7:0] c_lastCount  = 8'(STEPS - 1);

  logic [0:0]       r_fsmState;
  logic [0:0]       w_fsmNext;
  logic [7:0]       r_counter;
  logic [WIDTH-1:0] r_lfsrState;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_randomNumber;
  logic             r_numberValid;
  logic             r_periodWrap;
  logic             r_wrapSeen;

  logic             w_doLoad;
  logic             w_doStart;
  logic             w_doStep;
  logic             w_doFinish;
  logic             w_busy;
  logic [WIDTH-1:0] w_nextLfsr;
  logic [WIDTH-1:0] w_fillValue;
  logic             w_hitSeed;

  function automatic logic [WIDTH-1:0] lfsrStep(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign w_nextLfsr = lfsrStep(r_lfsrState);
  assign w_hitSeed  = (w_nextLfsr == r_seed);

`ifdef LFSR_LOCKUP_GUARD_EN
  // An all-zero state would never leave zero, so substitute the default seed.
  assign w_fillValue = (bus.initialFill == '0) ? DEFAULT_SEED : bus.initialFill;
`else
  assign w_fillValue = bus.initialFill;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_fsmState <= c_stateIdle;
    end else begin
      r_fsmState <= w_fsmNext;
    end
  end

  always_comb begin
    w_fsmNext = r_fsmState;
    case (r_fsmState)
      c_stateIdle: begin
        if (!bus.loadSeed && bus.generateNumber) begin
          w_fsmNext = c_stateShift;
        end
      end
      c_stateShift: begin
        if (bus.loadSeed || (r_counter == 8'd0)) begin
          w_fsmNext = c_stateIdle;
        end
      end
      default: w_fsmNext = c_stateIdle;
    endcase
  end

  // The first SHIFT cycle is not reported as busy, so STEPS=1 never shows busy.
  always_comb begin
    w_doLoad   = 1'b0;
    w_doStart  = 1'b0;
    w_doStep   = 1'b0;
    w_doFinish = 1'b0;
    w_busy     = 1'b0;
    case (r_fsmState)
      c_stateIdle: begin
        w_doLoad  = bus.loadSeed;
        w_doStart = !bus.loadSeed && bus.generateNumber;
      end
      c_stateShift: begin
        w_doLoad   = bus.loadSeed;
        w_doStep   = !bus.loadSeed;
        w_doFinish = !bus.loadSeed && (r_counter == 8'd0);
        w_busy     = (r_counter != c_lastCount);
      end
      default: begin
        w_doLoad = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_lfsrState    <= DEFAULT_SEED;
      r_seed         <= DEFAULT_SEED;
      r_randomNumber <= DEFAULT_SEED;
      r_counter      <= 8'd0;
      r_numberValid  <= 1'b0;
      r_periodWrap   <= 1'b0;
      r_wrapSeen     <= 1'b0;
    end else begin
      r_numberValid <= 1'b0;
      r_periodWrap  <= 1'b0;
      if (w_doLoad) begin
        r_lfsrState <= w_fillValue;
        r_seed      <= w_fillValue;
        r_wrapSeen  <= 1'b0;
      end else if (w_doStart) begin
        r_counter  <= c_lastCount;
        r_wrapSeen <= 1'b0;
      end else if (w_doStep) begin
        r_lfsrState <= w_nextLfsr;
        r_counter   <= r_counter - 8'd1;
        r_wrapSeen  <= r_wrapSeen | w_hitSeed;
        if (w_doFinish) begin
          r_randomNumber <= w_nextLfsr;
          r_numberValid  <= 1'b1;
          r_periodWrap   <= r_wrapSeen | w_hitSeed;
        end
      end
    end
  end

  assign bus.randomNumber = r_randomNumber;
  assign bus.numberValid  = r_numberValid;
  assign bus.periodWrap   = r_periodWrap;
  assign bus.busy         = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_random_generator.sv
// ============================================================================
// Module : tb_lfsr_random_generator
// Brief  : Directed checks of three generator configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lfsr_random_generator;

  logic clock = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  lfsr_random_generator_if #(.WIDTH(26)) busA ();
  lfsr_random_generator_if #(.WIDTH(26)) busB ();
  lfsr_random_generator_if #(.WIDTH(4))  busC ();

  lfsr_random_generator dutA (.clock(clock), .resetN(resetN), .bus(busA));
  lfsr_random_generator #(.STEPS(4)) dutB (.clock(clock), .resetN(resetN), .bus(busB));
  lfsr_random_generator #(.WIDTH(4), .TAPS(4'hC)) dutC (.clock(clock), .resetN(resetN), .bus(busC));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  expC [15];
    logic [25:0] zeroExp;
    logic        zeroWrap;
    expC = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
`ifdef LFSR_LOCKUP_GUARD_EN
    zeroExp  = 26'h3880000;
    zeroWrap = 1'b0;
`else
    zeroExp  = 26'h0;
    zeroWrap = 1'b1;
`endif
    {busA.initialFill, busA.loadSeed, busA.generateNumber} = '0;
    {busB.initialFill, busB.loadSeed, busB.generateNumber} = '0;
    {busC.initialFill, busC.loadSeed, busC.generateNumber} = '0;
    resetN = 1'b0;
    repeat (3) tick();

    check("rst A rn", busA.randomNumber, 26'h1);
    check("rst A valid", busA.numberValid, 1'b0);
    check("rst A busy", busA.busy, 1'b0);
    check("rst A wrap", busA.periodWrap, 1'b0);
    check("rst B rn", busB.randomNumber, 26'h1);
    check("rst C rn", busC.randomNumber, 4'h1);
    resetN = 1'b1;

    // Default configuration, one shift per number
    busA.initialFill = 26'h1; busA.loadSeed = 1'b1;
    tick();
    busA.loadSeed = 1'b0;
    check("A load valid", busA.numberValid, 1'b0);
    check("A load rn held", busA.randomNumber, 26'h1);
    busA.generateNumber = 1'b1;
    tick();
    busA.generateNumber = 1'b0;
    check("A gen1 busy", busA.busy, 1'b0);
    check("A gen1 early valid", busA.numberValid, 1'b0);
    tick();
    check("A gen1 valid", busA.numberValid, 1'b1);
    check("A gen1 rn", busA.randomNumber, 26'h3880000);
    check("A gen1 wrap", busA.periodWrap, 1'b0);
    tick();
    check("A gen1 pulse end", busA.numberValid, 1'b0);
    check("A gen1 rn hold", busA.randomNumber, 26'h3880000);
    busA.generateNumber = 1'b1;
    tick();
    busA.generateNumber = 1'b0;
    tick();
    check("A gen2 valid", busA.numberValid, 1'b1);
    check("A gen2 rn", busA.randomNumber, 26'h1C40000);

    // Simultaneous load and generate: load wins, request dropped
    busA.initialFill = 26'h5; busA.loadSeed = 1'b1; busA.generateNumber = 1'b1;
    tick();
    busA.loadSeed = 1'b0; busA.generateNumber = 1'b0;
    check("A ldgen valid0", busA.numberValid, 1'b0);
    tick();
    check("A ldgen valid1", busA.numberValid, 1'b0);
    check("A ldgen rn", busA.randomNumber, 26'h1C40000);
    busA.generateNumber = 1'b1;
    tick();
    busA.generateNumber = 1'b0;
    tick();
    check("A seed5 rn", busA.randomNumber, 26'h3880002);
    check("A seed5 wrap", busA.periodWrap, 1'b0);

    // All-zero seed
    busA.initialFill = 26'h0; busA.loadSeed = 1'b1;
    tick();
    busA.loadSeed = 1'b0; busA.generateNumber = 1'b1;
    tick();
    busA.generateNumber = 1'b0;
    tick();
    check("A zero valid", busA.numberValid, 1'b1);
    check("A zero rn", busA.randomNumber, zeroExp);
    check("A zero wrap", busA.periodWrap, zeroWrap);

    // 4-bit maximal sequence: 15 distinct values, wrap on the last
    busC.initialFill = 4'h1; busC.loadSeed = 1'b1;
    tick();
    busC.loadSeed = 1'b0;
    for (int i = 0; i < 15; i++) begin
      busC.generateNumber = 1'b1;
      tick();
      busC.generateNumber = 1'b0;
      tick();
      check($sformatf("C seq%0d valid", i), busC.numberValid, 1'b1);
      check($sformatf("C seq%0d rn", i), busC.randomNumber, expC[i]);
      check($sformatf("C seq%0d wrap", i), busC.periodWrap, (i == 14));
    end

    // STEPS=4: latency and busy window
    busB.initialFill = 26'h1; busB.loadSeed = 1'b1;
    tick();
    busB.loadSeed = 1'b0; busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    check("B k busy", busB.busy, 1'b0);
    for (int j = 1; j < 4; j++) begin
      tick();
      check($sformatf("B k+%0d busy", j), busB.busy, 1'b1);
      check($sformatf("B k+%0d valid", j), busB.numberValid, 1'b0);
    end
    tick();
    check("B done valid", busB.numberValid, 1'b1);
    check("B done rn", busB.randomNumber, 26'h0710000);
    check("B done wrap", busB.periodWrap, 1'b0);
    check("B done busy", busB.busy, 1'b0);

    // Generate pulsed while busy is ignored
    busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    tick();
    busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    tick();
    tick();
    check("B ign valid", busB.numberValid, 1'b1);
    check("B ign rn", busB.randomNumber, 26'h0071000);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("B ign noqueue%0d", j), busB.numberValid, 1'b0);
    end

    // Abort with a seed load on the second busy cycle
    busB.initialFill = 26'h1; busB.loadSeed = 1'b1;
    tick();
    busB.loadSeed = 1'b0; busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    tick();
    tick();
    check("B abort busy2", busB.busy, 1'b1);
    busB.initialFill = 26'h5; busB.loadSeed = 1'b1;
    tick();
    busB.loadSeed = 1'b0;
    check("B abort busy", busB.busy, 1'b0);
    check("B abort valid", busB.numberValid, 1'b0);
    tick();
    check("B abort valid late", busB.numberValid, 1'b0);
    check("B abort rn held", busB.randomNumber, 26'h0071000);
    busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    repeat (4) tick();
    check("B seed5 valid", busB.numberValid, 1'b1);
    // Four steps from 5: 3880002, 1C40001, 36A0000, 1B50000
    check("B seed5 rn", busB.randomNumber, 26'h1B50000);

    // Asynchronous reset in the middle of a request
    busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    tick();
    #2 resetN = 1'b0;
    #1;
    check("B arst busy", busB.busy, 1'b0);
    check("B arst rn", busB.randomNumber, 26'h1);
    check("B arst valid", busB.numberValid, 1'b0);
    tick();
    check("B arst valid after", busB.numberValid, 1'b0);
    resetN = 1'b1;
    busB.generateNumber = 1'b1;
    tick();
    busB.generateNumber = 1'b0;
    repeat (4) tick();
    check("B post-rst valid", busB.numberValid, 1'b1);
    check("B post-rst rn", busB.randomNumber, 26'h0710000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
